// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one SEG_W-bit segment per stage,
// with the segment carry registered into the next stage and a full-pipeline stall.
module cla_pipe_adder #(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int NSEG = WIDTH / SEG_W;
    localparam int NGRP = SEG_W / 4;

    // One segment: 4-bit lookahead groups, group carries rippled across the segment.
    // Returns {carry_out, sum}.
    function automatic logic [SEG_W:0] seg_cla(
        input logic [SEG_W-1:0] a,
        input logic [SEG_W-1:0] b,
        input logic             ci
    );
        logic [SEG_W-1:0] g;
        logic [SEG_W-1:0] p;
        logic [SEG_W:0]   c;
        logic             gg;
        logic             pp;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = ci;
        for (int k = 0; k < NGRP; k++) begin
            c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
            gg = g[4*k+3] | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            pp = &p[4*k +: 4];
            c[4*k+4] = gg | (pp & c[4*k]);
        end
        return {c[SEG_W], p ^ c[SEG_W-1:0]};
    endfunction

    // Per-stage registers. a_q/b_q carry the operands (B already inverted for
    // subtract) forward; only the slices above the completed ones are consumed.
    logic             v_q [NSEG];
    logic             c_q [NSEG];
    logic [WIDTH-1:0] a_q [NSEG];
    logic [WIDTH-1:0] b_q [NSEG];
    logic [WIDTH-1:0] s_q [NSEG];
    logic             ovf_q;
    logic             zero_q;
    logic             advance;

    // Handshake: a transfer happens on a rising edge where valid & ready are both
    // high on that side. The whole pipeline advances together when the output slot
    // is empty or being consumed; otherwise every stage holds. in_ready depends
    // only on out_ready/out_valid, never on in_valid.
    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;

    for (genvar i = 0; i < NSEG; i++) begin : g_stage
        logic             v_in;
        logic             c_in;
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] s_in;
        logic [WIDTH-1:0] s_nx;
        logic [SEG_W:0]   seg_res;

        if (i == 0) begin : g_head
            assign v_in = in_valid;
            assign a_in = A;
            assign b_in = sub ? ~B : B;
            assign c_in = sub | cin;
            assign s_in = '0;
        end else begin : g_body
            assign v_in = v_q[i-1];
            assign a_in = a_q[i-1];
            assign b_in = b_q[i-1];
            assign c_in = c_q[i-1];
            assign s_in = s_q[i-1];
        end

        assign seg_res = seg_cla(a_in[i*SEG_W +: SEG_W], b_in[i*SEG_W +: SEG_W], c_in);

        always_comb begin
            s_nx                   = s_in;
            s_nx[i*SEG_W +: SEG_W] = seg_res[SEG_W-1:0];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q[i] <= 1'b0;
                c_q[i] <= 1'b0;
                a_q[i] <= '0;
                b_q[i] <= '0;
                s_q[i] <= '0;
            end else if (advance) begin
                v_q[i] <= v_in;
                c_q[i] <= seg_res[SEG_W];
                a_q[i] <= a_in;
                b_q[i] <= b_in;
                s_q[i] <= s_nx;
            end
        end

        if (i == NSEG - 1) begin : g_tail
            // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (advance) begin
                    ovf_q  <= seg_res[SEG_W] ^ a_in[WIDTH-1] ^ b_in[WIDTH-1] ^ s_nx[WIDTH-1];
                    zero_q <= ~|s_nx;
                end
            end
        end
    end

    assign out_valid = v_q[NSEG-1];
    assign sum       = s_q[NSEG-1];
    assign cout      = c_q[NSEG-1];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: 32/8, 16/4 and 8/8 instances with directed vectors,
// a scoreboard on the 32-bit instance, backpressure and mid-flight reset.
module tb_cla_pipe_adder;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 32-bit instance
    logic        iv0, ir0, ci0, sb0, ov0, or0, co0, of0, z0;
    logic [31:0] a0, b0, s0;
    // 16-bit / 4-bit segment instance
    logic        iv1, ir1, ci1, sb1, ov1, co1, of1, z1;
    logic [15:0] a1, b1, s1;
    // 8-bit single-stage instance
    logic        iv2, ir2, ci2, sb2, ov2, co2, of2, z2;
    logic [7:0]  a2, b2, s2;
    logic        or_s;

    cla_pipe_adder #(.WIDTH(32), .SEG_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .A(a0), .B(b0),
        .cin(ci0), .sub(sb0), .out_valid(ov0), .out_ready(or0), .sum(s0),
        .cout(co0), .ovf(of0), .zero(z0));

    cla_pipe_adder #(.WIDTH(16), .SEG_W(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .A(a1), .B(b1),
        .cin(ci1), .sub(sb1), .out_valid(ov1), .out_ready(or_s), .sum(s1),
        .cout(co1), .ovf(of1), .zero(z1));

    cla_pipe_adder #(.WIDTH(8), .SEG_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .A(a2), .B(b2),
        .cin(ci2), .sub(sb2), .out_valid(ov2), .out_ready(or_s), .sum(s2),
        .cout(co2), .ovf(of2), .zero(z2));

    // scoreboard state
    int          checks = 0;
    int          errors = 0;
    int          n_out  = 0;
    logic        check_lat = 1'b1;
    logic [34:0] exp_q[$];
    int          acc_q[$];
    logic [34:0] mon_e;
    int          mon_acc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // reference: {zero, ovf, cout, sum}
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic ci, input logic sb);
        logic [31:0] be;
        logic [32:0] full;
        logic        ov;
        be   = sb ? ~b : b;
        full = {1'b0, a} + {1'b0, be} + {32'd0, (sb ? 1'b1 : ci)};
        ov   = (a[31] == be[31]) && (full[31] != a[31]);
        return {full[31:0] == 32'd0, ov, full[32], full[31:0]};
    endfunction

    // {valid, cout, ovf, zero, sum zero-extended}
    function automatic logic [35:0] get_out(input int d);
        case (d)
            0:       return {ov0, co0, of0, z0, s0};
            1:       return {ov1, co1, of1, z1, 16'd0, s1};
            default: return {ov2, co2, of2, z2, 24'd0, s2};
        endcase
    endfunction

    // driver tasks
    task automatic drive(input int d, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic sb);
        case (d)
            0:       begin iv0 = v; a0 = a;        b0 = b;        ci0 = ci; sb0 = sb; end
            1:       begin iv1 = v; a1 = a[15:0];  b1 = b[15:0];  ci1 = ci; sb1 = sb; end
            default: begin iv2 = v; a2 = a[7:0];   b2 = b[7:0];   ci2 = ci; sb2 = sb; end
        endcase
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic ci,
                        input logic sb, input logic push);
        int n;
        @(posedge clk); #1;
        drive(0, 1'b1, a, b, ci, sb);
        n = 0;
        @(negedge clk);
        while (!ir0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_in_ready", ir0, 1);
        if (push) begin
            exp_q.push_back(model(a, b, ci, sb));
            acc_q.push_back(cyc);
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        iv0 = 1'b0;
    endtask

    // single operand into an empty pipeline; checks latency and all result fields
    task automatic run_one(input int d, input logic [31:0] a, input logic [31:0] b,
                           input logic ci, input logic sb, input logic [31:0] es,
                           input logic [2:0] ef, input string tag);
        int          n;
        logic [35:0] o;
        int          w;
        w = (d == 0) ? 32 : (d == 1) ? 16 : 8;
        @(posedge clk); #1;
        drive(d, 1'b1, a, b, ci, sb);
        if (d == 0) begin
            exp_q.push_back(model(a, b, ci, sb));
            acc_q.push_back(cyc);
        end
        @(posedge clk); #1;
        drive(d, 1'b0, a, b, ci, sb);
        n = 1;
        o = '0;
        while (n <= 20) begin
            @(negedge clk);
            o = get_out(d);
            if (o[35]) break;
            n++;
        end
        check($sformatf("%s_w%0d_latency", tag, w), n, (d == 2) ? 1 : 4);
        check($sformatf("%s_w%0d_sum", tag, w), o[31:0], es);
        check($sformatf("%s_w%0d_flags", tag, w), o[34:32], ef);
    endtask

    // scoreboard monitor on the 32-bit instance
    always @(negedge clk) begin
        if (!rst && ov0 && or0) begin
            if (exp_q.size() == 0) begin
                check("extra_result", exp_q.size(), 1);
            end else begin
                mon_e   = exp_q.pop_front();
                mon_acc = acc_q.pop_front();
                check("sb_result", {z0, of0, co0, s0}, mon_e);
                if (check_lat) check("sb_latency", cyc - mon_acc, 4);
                n_out++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ones, msb, a, b;
        int          base, n, seen;

        rst = 1'b1; or0 = 1'b0; or_s = 1'b1;
        drive(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        drive(1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        drive(2, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", ov0, 0);
        check("rst_sum", s0, 0);
        check("rst_flags", {co0, of0, z0}, 0);
        check("rst_in_ready", ir0, 1);
        check("rst_out_valid_w16", ov1, 0);
        check("rst_out_valid_w8", ov2, 0);
        or0 = 1'b1;

        // directed vectors on each width; expectations from width constants
        for (int d = 0; d < 3; d++) begin
            ones = (d == 0) ? 32'hFFFF_FFFF : (d == 1) ? 32'h0000_FFFF : 32'h0000_00FF;
            msb  = (d == 0) ? 32'h8000_0000 : (d == 1) ? 32'h0000_8000 : 32'h0000_0080;
            run_one(d, 32'd128, 32'd64, 1'b1, 1'b0, 32'd193,    3'b000, "add");
            run_one(d, ones,    32'd0,  1'b1, 1'b0, 32'd0,      3'b101, "carry_all");
            run_one(d, msb - 1, 32'd1,  1'b0, 1'b0, msb,        3'b010, "add_ovf");
            run_one(d, 32'd5,   32'd7,  1'b1, 1'b1, ones - 1,   3'b000, "sub_borrow");
            run_one(d, msb,     32'd1,  1'b0, 1'b1, msb - 1,    3'b110, "sub_ovf");
        end

        // back-to-back stream of 16
        base = n_out;
        for (int i = 0; i < 16; i++) begin
            a = 32'h9E37_79B9 * 32'(i + 1);
            b = {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
            send(a, b, i[0], i[1], 1'b1);
        end
        idle();
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("stream_drain", exp_q.size(), 0);
        check("stream_count", n_out - base, 16);

        // backpressure: out_ready low for 3 cycles mid-stream
        check_lat = 1'b0;
        base = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    a = 32'h0100_0000 * 32'(i + 3) + 32'(i);
                    b = 32'h00FF_00FF << i;
                    send(a, b, i[1], i[0], 1'b1);
                end
                idle();
            end
            begin
                repeat (5) @(posedge clk);
                #1 or0 = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_in_ready", ir0, 0);
                    check("stall_out_valid", ov0, 1);
                    check("stall_sum_held", s0,
                          (exp_q.size() > 0) ? exp_q[0][31:0] : ~s0);
                end
                @(posedge clk);
                #1 or0 = 1'b1;
            end
        join
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("bp_drain", exp_q.size(), 0);
        check("bp_count", n_out - base, 8);
        check_lat = 1'b1;

        // reset with three operands in flight
        send(32'd100, 32'd1, 1'b0, 1'b0, 1'b0);
        send(32'd200, 32'd2, 1'b0, 1'b0, 1'b0);
        send(32'd300, 32'd3, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        iv0 = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", ov0, 0);
        check("midrst_sum", s0, 0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (ov0) seen++;
        end
        check("midrst_no_leak", seen, 0);
        run_one(0, 32'd10, 32'd20, 1'b0, 1'b0, 32'd30, 3'b000, "post_rst");

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("final_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
